fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for one radix-2 DIF FFT stage: issues N/2 butterfly pairs, then drains results.
// Optional drain watchdog is compiled in when FFT_SEQ_WATCHDOG_EN is defined.
module fft_stage_sequencer #(
   parameter int FFT_N     = 10,
   parameter int FFT_STAGE = 0,
   parameter int BFLY_LAT  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             rd_en,
   output logic [FFT_N-1:0] rd_addr_a,
   output logic [FFT_N-1:0] rd_addr_b,
   output logic [FFT_N-2:0] tw_addr,
   output logic             bfly_iact,
   output logic [1:0]       bfly_ictrl,
   output logic [FFT_N-2:0] bfly_addr,
   input  logic             bfly_oact
);

   localparam logic [FFT_N-2:0] K_ZERO = {(FFT_N-1){1'b0}};
   localparam logic [FFT_N-2:0] K_LAST = {(FFT_N-1){1'b1}};
   localparam logic [FFT_N-2:0] K_ONE  = (FFT_N-1)'(1'b1);
   // J_MASK = span-1; the bits of k above it form the group index g.
   localparam logic [FFT_N-2:0] J_MASK = K_LAST >> FFT_STAGE;
   localparam logic [FFT_N-1:0] SPAN   = {1'b0, J_MASK} + FFT_N'(1'b1);
   localparam logic [FFT_N-1:0] HALF   = {1'b1, K_ZERO};

   if (FFT_N < 2 || FFT_STAGE < 0 || FFT_STAGE >= FFT_N || BFLY_LAT < 1) begin : g_bad_param
      $error("fft_stage_sequencer: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [FFT_N-2:0] k_r;
   logic [FFT_N-1:0] oact_cnt_r;
   logic [FFT_N-1:0] oact_sum_s;
   logic             issue_s;
   logic             wd_expire_s;
   logic [FFT_N-2:0] j_s;
   logic [FFT_N-1:0] addr_a_s;
   logic             bfly_iact_r;
   logic [1:0]       bfly_ictrl_r;
   logic [FFT_N-2:0] bfly_addr_r;

   assign oact_sum_s = oact_cnt_r + {K_ZERO, bfly_oact};
   assign j_s        = k_r & J_MASK;
   // Inserting a zero bit at the span position turns pair index k into g*2*span + j.
   assign addr_a_s   = {k_r & ~J_MASK, 1'b0} | {1'b0, j_s};

`ifdef FFT_SEQ_WATCHDOG_EN
   localparam int              WD_W    = $clog2(4*BFLY_LAT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(4*BFLY_LAT - 1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            err_r;

   assign wd_expire_s = (state_r == DRAIN) && (wd_cnt_r == WD_LAST);
   assign err         = err_r;

   // Drain-cycle counter and sticky error flag; only a completed drain escapes the error.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_r <= {WD_W{1'b0}};
         err_r    <= 1'b0;
      end else begin
         if (state_r == DRAIN) wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
         else                  wd_cnt_r <= {WD_W{1'b0}};
         if (wd_expire_s && (oact_sum_s != HALF)) err_r <= 1'b1;
         else                                     err_r <= err_r;
      end
   end
`else
   assign wd_expire_s = 1'b0;
   assign err         = 1'b0;
`endif

   // Next-state and issue decision.
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) state_s = ISSUE;
            else       state_s = IDLE;
         end
         ISSUE: begin
            if (!hold) begin
               issue_s = 1'b1;
               if (k_r == K_LAST) state_s = DRAIN;
               else               state_s = ISSUE;
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if (oact_sum_s == HALF) state_s = DONE;
            else if (wd_expire_s)   state_s = DONE;
            else                    state_s = DRAIN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, pair counter, result counter and the one-cycle memory-latency pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         k_r          <= K_ZERO;
         oact_cnt_r   <= {FFT_N{1'b0}};
         bfly_iact_r  <= 1'b0;
         bfly_ictrl_r <= 2'b00;
         bfly_addr_r  <= K_ZERO;
      end else begin
         state_r <= state_s;
         if (state_s == IDLE) k_r <= K_ZERO;
         else if (issue_s)    k_r <= k_r + K_ONE;
         else                 k_r <= k_r;
         if (state_s == IDLE)                             oact_cnt_r <= {FFT_N{1'b0}};
         else if ((state_r == ISSUE) || (state_r == DRAIN)) oact_cnt_r <= oact_sum_s;
         else                                             oact_cnt_r <= oact_cnt_r;
         bfly_iact_r <= issue_s;
         if (issue_s) bfly_ictrl_r <= {k_r == K_LAST, k_r == K_ZERO};
         else         bfly_ictrl_r <= 2'b00;
         bfly_addr_r <= k_r;
      end
   end

   // Addresses follow k throughout ISSUE (held while hold is high) and read zero elsewhere.
   always_comb begin
      if (state_r == ISSUE) begin
         rd_addr_a = addr_a_s;
         rd_addr_b = addr_a_s | SPAN;
         tw_addr   = j_s << FFT_STAGE;
      end else begin
         rd_addr_a = {FFT_N{1'b0}};
         rd_addr_b = {FFT_N{1'b0}};
         tw_addr   = K_ZERO;
      end
   end

   assign busy       = (state_r != IDLE);
   assign done       = (state_r == DONE);
   assign rd_en      = issue_s;
   assign bfly_iact  = bfly_iact_r;
   assign bfly_ictrl = bfly_ictrl_r;
   assign bfly_addr  = bfly_addr_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: three stages (s=0,1,2) of an N=8 transform run in lockstep
// against a behavioural pass model, plus literal address tables and latency checks.
module tb_fft_stage_sequencer;

   localparam int FN  = 3;
   localparam int LAT = 6;
   localparam int NP  = 4;
   localparam int NS  = 3;
`ifdef FFT_SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic start    = 1'b0;
   logic hold     = 1'b0;
   logic withhold = 1'b0;
   logic bfly_oact;

   logic          busy[NS], done[NS], err[NS], rd_en[NS], bfly_iact[NS];
   logic [FN-1:0] rd_addr_a[NS], rd_addr_b[NS];
   logic [FN-2:0] tw_addr[NS], bfly_addr[NS];
   logic [1:0]    bfly_ictrl[NS];
   logic [LAT-1:0] iact_pipe = '0;
   logic [LAT-1:0] last_pipe = '0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NS; g++) begin : g_dut
      fft_stage_sequencer #(.FFT_N(FN), .FFT_STAGE(g), .BFLY_LAT(LAT)) u_dut (
         .clk(clk), .reset(reset), .start(start), .hold(hold),
         .busy(busy[g]), .done(done[g]), .err(err[g]), .rd_en(rd_en[g]),
         .rd_addr_a(rd_addr_a[g]), .rd_addr_b(rd_addr_b[g]), .tw_addr(tw_addr[g]),
         .bfly_iact(bfly_iact[g]), .bfly_ictrl(bfly_ictrl[g]), .bfly_addr(bfly_addr[g]),
         .bfly_oact(bfly_oact)
      );
   end

   // Butterfly stand-in: returns each iact LAT cycles later, optionally dropping the last pair.
   always @(posedge clk) begin
      iact_pipe <= {iact_pipe[LAT-2:0], bfly_iact[0]};
      last_pipe <= {last_pipe[LAT-2:0], bfly_ictrl[0][1]};
   end
   assign bfly_oact = iact_pipe[LAT-1] & ~(withhold & last_pipe[LAT-1]);

   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit m_active = 1'b0, m_fin = 1'b0, m_err = 1'b0;
   int m_k = 0, m_got = 0, m_wait = 0;
   bit e_iact = 1'b0;
   logic [1:0] e_ictrl = 2'b00;
   int e_baddr = 0;
   bit issuing, e_rd;
   int n_rd = 0, n_done = 0, done_cyc = -1, s_cyc = 0;
   int qa[NS][$], qb[NS][$], qt[NS][$];
   int qc[$], rc[$];

   int TA[NS][NP] = '{'{0, 1, 2, 3}, '{0, 1, 4, 5}, '{0, 2, 4, 6}};
   int TB[NS][NP] = '{'{4, 5, 6, 7}, '{2, 3, 6, 7}, '{1, 3, 5, 7}};
   int TT[NS][NP] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};
   int TC[NP]     = '{1, 0, 0, 2};
   int TR[NP]     = '{1, 2, 6, 7};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", name, idx, cyc, act, exp);
      end
   endtask

   function automatic int span_of(input int s);
      return (1 << FN) >> (s + 1);
   endfunction

   function automatic int exp_a(input int s, input int k);
      return (k >> (FN - 1 - s)) * 2 * span_of(s) + (k & (span_of(s) - 1));
   endfunction

   function automatic int exp_tw(input int s, input int k);
      return (k & (span_of(s) - 1)) << s;
   endfunction

   // Per-cycle comparison against the pass model, then advance the model over the coming edge.
   always @(negedge clk) begin
      issuing = m_active && !m_fin && (m_k < NP);
      e_rd    = issuing && !hold;
      for (int g = 0; g < NS; g++) begin
         chk("busy", g, busy[g], m_active);
         chk("done", g, done[g], m_fin);
         chk("err", g, err[g], m_err);
         chk("rd_en", g, rd_en[g], e_rd);
         chk("rd_addr_a", g, rd_addr_a[g], issuing ? exp_a(g, m_k) : 0);
         chk("rd_addr_b", g, rd_addr_b[g], issuing ? exp_a(g, m_k) + span_of(g) : 0);
         chk("tw_addr", g, tw_addr[g], issuing ? exp_tw(g, m_k) : 0);
         chk("bfly_iact", g, bfly_iact[g], e_iact);
         chk("bfly_ictrl", g, bfly_ictrl[g], e_ictrl);
         if (e_iact) chk("bfly_addr", g, bfly_addr[g], e_baddr);
         if (rd_en[g]) begin
            qa[g].push_back(int'(rd_addr_a[g]));
            qb[g].push_back(int'(rd_addr_b[g]));
            qt[g].push_back(int'(tw_addr[g]));
         end
      end
      if (rd_en[0]) begin
         n_rd++;
         rc.push_back(cyc);
      end
      if (bfly_iact[0]) qc.push_back(int'(bfly_ictrl[0]));
      if (done[0]) begin
         n_done++;
         done_cyc = cyc;
      end
      if (reset) begin
         m_active = 1'b0; m_fin = 1'b0; m_err = 1'b0;
         m_k = 0; m_got = 0; m_wait = 0;
         e_iact = 1'b0; e_ictrl = 2'b00;
      end else begin
         e_iact  = e_rd;
         e_ictrl = e_rd ? {m_k == NP - 1, m_k == 0} : 2'b00;
         e_baddr = m_k;
         if (!m_active) begin
            if (start) begin
               m_active = 1'b1; m_k = 0; m_got = 0; m_wait = 0;
            end
         end else if (m_fin) begin
            m_active = 1'b0; m_fin = 1'b0;
         end else if (m_k < NP) begin
            if (bfly_oact) m_got++;
            if (!hold) m_k++;
         end else begin
            if (bfly_oact) m_got++;
            if (m_got == NP) m_fin = 1'b1;
            else if (WD && m_wait == 4*LAT - 1) begin
               m_fin = 1'b1; m_err = 1'b1;
            end else m_wait++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      s_cyc = cyc;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_tables(input int b_q, input int b_c);
      for (int g = 0; g < NS; g++) begin
         chk("n_issue", g, qa[g].size() - b_q, NP);
         for (int i = 0; i < NP; i++) begin
            if (b_q + i < qa[g].size()) begin
               chk("tab_a", g*10 + i, qa[g][b_q+i], TA[g][i]);
               chk("tab_b", g*10 + i, qb[g][b_q+i], TB[g][i]);
               chk("tab_tw", g*10 + i, qt[g][b_q+i], TT[g][i]);
            end
         end
      end
      for (int i = 0; i < NP; i++)
         if (b_c + i < qc.size()) chk("tab_ictrl", i, qc[b_c+i], TC[i]);
   endtask

   initial begin
      int b_q, b_c, b_rd, b_dn, b_r;
      tick(3);
      reset = 1'b0;
      tick(2);

      // Plain pass: address tables for all three stages, single done, done 12 cycles after start.
      b_q = qa[0].size(); b_c = qc.size(); b_rd = n_rd; b_dn = n_done;
      do_start();
      tick(20);
      chk("lat_plain", 0, done_cyc - s_cyc, 1 + NP - 1 + LAT + 2);
      chk("n_rd_plain", 0, n_rd - b_rd, NP);
      chk("n_done_plain", 0, n_done - b_dn, 1);
      check_tables(b_q, b_c);

      // Hold for three cycles after the second issue.
      b_q = qa[0].size(); b_c = qc.size(); b_r = rc.size(); b_dn = n_done;
      do_start();
      tick(2);
      hold = 1'b1;
      tick(3);
      hold = 1'b0;
      tick(20);
      for (int i = 0; i < NP; i++)
         if (b_r + i < rc.size()) chk("hold_rd_cycle", i, rc[b_r+i] - s_cyc, TR[i]);
      chk("lat_hold", 0, done_cyc - s_cyc, 15);
      chk("n_done_hold", 0, n_done - b_dn, 1);
      check_tables(b_q, b_c);

      // start kept high while busy, including the DONE cycle.
      b_rd = n_rd; b_dn = n_done;
      do_start();
      for (int i = 0; i < 25; i++) begin
         start = busy[0];
         tick(1);
      end
      start = 1'b0;
      chk("n_rd_restart", 0, n_rd - b_rd, NP);
      chk("n_done_restart", 0, n_done - b_dn, 1);
      chk("lat_restart", 0, done_cyc - s_cyc, 12);

      // Reset in DRAIN, stale oacts arrive in IDLE, then a clean pass.
      b_dn = n_done;
      do_start();
      tick(7);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      for (int g = 0; g < NS; g++) chk("busy_after_reset", g, busy[g], 1'b0);
      tick(12);
      chk("n_done_reset", 0, n_done - b_dn, 0);
      b_q = qa[0].size(); b_c = qc.size(); b_dn = n_done;
      do_start();
      tick(20);
      chk("lat_after_reset", 0, done_cyc - s_cyc, 12);
      chk("n_done_after_reset", 0, n_done - b_dn, 1);
      check_tables(b_q, b_c);

      // Last oact withheld.
      b_dn = n_done;
      withhold = 1'b1;
      do_start();
      tick(40);
`ifdef FFT_SEQ_WATCHDOG_EN
      chk("lat_watchdog", 0, done_cyc - s_cyc, 1 + NP + 4*LAT);
      chk("n_done_watchdog", 0, n_done - b_dn, 1);
      for (int g = 0; g < NS; g++) begin
         chk("err_sticky", g, err[g], 1'b1);
         chk("busy_after_wd", g, busy[g], 1'b0);
      end
`else
      chk("n_done_stall", 0, n_done - b_dn, 0);
      for (int g = 0; g < NS; g++) begin
         chk("busy_stall", g, busy[g], 1'b1);
         chk("err_stall", g, err[g], 1'b0);
      end
`endif
      withhold = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(2);
      for (int g = 0; g < NS; g++) begin
         chk("err_cleared", g, err[g], 1'b0);
         chk("busy_cleared", g, busy[g], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
